cell_fetcher: RTL and testbench

Pixel-fetch stage directly downstream of the cursor scanner. It drives the scanner's step enable, samples the scanner's (x, y) on every step, and turns each position into a linear address `y*width + x` for a synchronous cell memory. The returned data is buffered in a small FIFO and presented as a valid/ready pixel stream tagged with start-of-frame, end-of-line and end-of-frame markers for the VGA output stage.

---
 rtl/cell_fetcher.sv | 125 ++++++++++++
 tb/tb_cell_fetcher.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_fetcher.sv
// cell_fetcher: pixel-fetch stage behind the cursor scanner.
// Steps the scanner under a credit rule, reads the cell memory at y*width+x,
// buffers returned data with frame tags in a small FIFO and presents it as a
// valid/ready pixel stream.
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   run                    permit stepping; low pauses fetching
//   width, height          grid dimensions (>= 1)
//   x, y                   scanner position
//   scan_en                scanner step enable / sample strobe (combinational)
//   mem_rd_en, mem_addr    memory read strobe and address
//   mem_rdata              read data, valid one cycle after mem_rd_en
//   pix_valid, pix_ready   output handshake
//   pix_data, pix_sof, pix_eol, pix_eof  head pixel and its tags
module cell_fetcher #(
  parameter int unsigned X_BITS     = 3,
  parameter int unsigned Y_BITS     = 3,
  parameter int unsigned DATA_BITS  = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       run,
  input  logic [X_BITS:0]            width,
  input  logic [Y_BITS:0]            height,
  input  logic [X_BITS-1:0]          x,
  input  logic [Y_BITS-1:0]          y,
  output logic                       scan_en,
  output logic                       mem_rd_en,
  output logic [X_BITS+Y_BITS-1:0]   mem_addr,
  input  logic [DATA_BITS-1:0]       mem_rdata,
  output logic                       pix_valid,
  input  logic                       pix_ready,
  output logic [DATA_BITS-1:0]       pix_data,
  output logic                       pix_sof,
  output logic                       pix_eol,
  output logic                       pix_eof
);

  localparam int unsigned ADDR_BITS = X_BITS + Y_BITS;
  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned ENT_W     = DATA_BITS + 3;

  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             inflight_q;
  logic             sof_q, eol_q, eof_q;
  logic [ENT_W-1:0] fifo_q [FIFO_DEPTH];

  logic [CNT_W:0]   occupancy;
  logic [X_BITS:0]  width_m1;
  logic [Y_BITS:0]  height_m1;
  logic             sof_c, eol_c, eof_c;
  logic             push, pop;
  logic [ENT_W-1:0] head;

  // Credit rule: FIFO entries plus the outstanding read never exceed the depth.
  always_comb begin
    occupancy = (CNT_W+1)'(count_q) + (CNT_W+1)'(inflight_q);
    scan_en   = reset_n & run & (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    mem_rd_en = scan_en;
  end

  // Linear address, wide enough for any in-range position.
  always_comb begin
    mem_addr = ADDR_BITS'(y) * ADDR_BITS'(width) + ADDR_BITS'(x);
  end

  // Frame tags for the position being sampled; x >= width yields no eol/eof.
  always_comb begin
    width_m1  = width - (X_BITS+1)'(1);
    height_m1 = height - (Y_BITS+1)'(1);
    sof_c     = (x == '0) && (y == '0);
    eol_c     = ({1'b0, x} == width_m1);
    eof_c     = eol_c && ({1'b0, y} == height_m1);
  end

  // FIFO bookkeeping and head presentation; outputs are zero when empty.
  always_comb begin
    push      = inflight_q;
    pix_valid = (count_q != '0);
    pop       = pix_valid & pix_ready;
    count_d   = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    head     = fifo_q[rd_ptr_q];
    pix_data = pix_valid ? head[ENT_W-1:3] : '0;
    pix_sof  = pix_valid & head[2];
    pix_eol  = pix_valid & head[1];
    pix_eof  = pix_valid & head[0];
  end

  // Control state; reset drops the in-flight read so its data is never pushed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= scan_en;
      sof_q      <= sof_c;
      eol_q      <= eol_c;
      eof_q      <= eof_c;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // FIFO storage; contents are masked at the output while empty.
  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      fifo_q[wr_ptr_q] <= {mem_rdata, sof_q, eol_q, eof_q};
    end
  end

endmodule

// File: tb/tb_cell_fetcher.sv
// Self-checking bench for cell_fetcher: scanner and memory models, scoreboard
// of expected pixels pushed on each sampled position and popped on each
// accepted output beat.
module tb_cell_fetcher;

  localparam int unsigned XB = 3;
  localparam int unsigned YB = 3;
  localparam int unsigned DB = 12;
  localparam int unsigned FD = 4;
  localparam int unsigned AB = XB + YB;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  logic pix_ready = 1'b0;
  logic scan_rst = 1'b1;
  logic [XB:0] width = 4'd3;
  logic [YB:0] height = 4'd2;
  logic [XB-1:0] x;
  logic [YB-1:0] y;
  logic scan_en, mem_rd_en, pix_valid, pix_sof, pix_eol, pix_eof;
  logic [AB-1:0] mem_addr;
  logic [DB-1:0] mem_rdata, pix_data;
  logic [DB-1:0] mem [64];

  typedef struct packed {
    logic [DB-1:0] data;
    logic sof;
    logic eol;
    logic eof;
  } exp_t;

  exp_t sb[$];
  int nchk = 0;
  int nfail = 0;
  int npop = 0;
  int nscan = 0;
  int nsof = 0;
  int neol = 0;
  int neof = 0;

  cell_fetcher #(.X_BITS(XB), .Y_BITS(YB), .DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .width(width), .height(height),
    .x(x), .y(y), .scan_en(scan_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = DB'(i);
  end

  // Raster scanner model: steps on scan_en, wraps at width/height.
  always @(posedge clk) begin
    if (scan_rst) begin
      x <= '0;
      y <= '0;
    end else if (scan_en) begin
      if (int'(x) + 1 >= int'(width)) begin
        x <= '0;
        if (int'(y) + 1 >= int'(height)) y <= '0;
        else y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Synchronous memory: data one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    else mem_rdata <= 12'hEEE;
  end

  // Scoreboard: sampled at the falling edge, reflecting the upcoming rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    exp_t got;
    int a;
    if (!reset_n) begin
      sb.delete();
    end else begin
      if (pix_valid && pix_ready) begin
        nchk++;
        npop++;
        got = {pix_data, pix_sof, pix_eol, pix_eof};
        if (pix_sof) nsof++;
        if (pix_eol) neol++;
        if (pix_eof) neof++;
        if (sb.size() == 0) begin
          nfail++;
          $display("FAIL pop_empty: got data=%0d sof=%b eol=%b eof=%b, required no pixel",
                   pix_data, pix_sof, pix_eol, pix_eof);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            nfail++;
            $display("FAIL pixel: got data=%0d sof=%b eol=%b eof=%b, required data=%0d sof=%b eol=%b eof=%b",
                     got.data, got.sof, got.eol, got.eof, e.data, e.sof, e.eol, e.eof);
          end
        end
      end
      if (scan_en) begin
        nscan++;
        a = int'(y) * int'(width) + int'(x);
        e.data = DB'(a);
        e.sof  = (x == 0) && (y == 0);
        e.eol  = (int'(x) == int'(width) - 1);
        e.eof  = e.eol && (int'(y) == int'(height) - 1);
        sb.push_back(e);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    pix_ready = 1'b0;
    reset_n = 1'b0;
    scan_rst = 1'b1;
    step();
    step();
    reset_n = 1'b1;
    scan_rst = 1'b0;
  endtask

  task automatic drain(input string name);
    int i;
    run = 1'b0;
    pix_ready = 1'b1;
    for (i = 0; i < 30; i++) begin
      step();
      if (sb.size() == 0 && !pix_valid) break;
    end
    nchk++;
    if (sb.size() != 0 || pix_valid) begin
      nfail++;
      $display("FAIL %s_drain: %0d pixels still expected, pix_valid=%b, required 0/0",
               name, sb.size(), pix_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    scan_rst = 1'b1;
    run = 1'b1;
    pix_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    nchk++;
    if ({scan_en, mem_rd_en, pix_valid} !== 3'b000) begin
      nfail++;
      $display("FAIL reset_ctrl: scan_en/mem_rd_en/pix_valid=%b%b%b, required 000",
               scan_en, mem_rd_en, pix_valid);
    end
    nchk++;
    if ({pix_data, pix_sof, pix_eol, pix_eof} !== '0) begin
      nfail++;
      $display("FAIL reset_pix: data=%0d sof=%b eol=%b eof=%b, required all 0",
               pix_data, pix_sof, pix_eol, pix_eof);
    end
    do_reset();
  endtask

  task automatic test_raster();
    int fs = -1;
    int fv = -1;
    int vcnt = 0;
    do_reset();
    width = 4'd3;
    height = 4'd2;
    pix_ready = 1'b1;
    run = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (scan_en && fs < 0) fs = c;
      if (pix_valid && fv < 0) fv = c;
      if (fv >= 0 && pix_valid) vcnt++;
    end
    nchk++;
    if (fs < 0 || fv - fs != 2) begin
      nfail++;
      $display("FAIL raster_latency: first valid %0d cycles after first scan, required 2", fv - fs);
    end
    nchk++;
    if (fv < 0 || vcnt != 30 - fv) begin
      nfail++;
      $display("FAIL raster_throughput: %0d valid cycles, required %0d", vcnt, 30 - fv);
    end
    step();
    drain("raster");
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    int bad = 0;
    int gaps = 0;
    do_reset();
    width = 4'd3;
    height = 4'd2;
    run = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (scan_en) pulses++;
      if (c >= 6 && (!pix_valid || pix_data !== 12'd0 || !pix_sof)) bad++;
    end
    nchk++;
    if (pulses != 4) begin
      nfail++;
      $display("FAIL bp_pulses: %0d scan_en pulses, required 4", pulses);
    end
    nchk++;
    if (scan_en !== 1'b0) begin
      nfail++;
      $display("FAIL bp_hold: scan_en=%b, required 0", scan_en);
    end
    nchk++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL bp_stable: %0d cycles head not valid data 0 with sof, required 0", bad);
    end
    step();
    pix_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!pix_valid) gaps++;
    end
    nchk++;
    if (gaps != 0) begin
      nfail++;
      $display("FAIL bp_release_gaps: %0d empty cycles, required 0", gaps);
    end
    step();
  endtask

  task automatic test_pause();
    int found = 0;
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (x == 1) begin
        found = 1;
        break;
      end
    end
    nchk++;
    if (found == 0) begin
      nfail++;
      $display("FAIL pause_find: x never reached 1 (x=%0d), required 1", x);
    end
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (scan_en !== 1'b0) bad++;
      step();
    end
    nchk++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL pause_scan: scan_en high in %0d paused cycles, required 0", bad);
    end
    run = 1'b1;
    repeat (15) step();
    drain("pause");
  endtask

  task automatic test_full_grid();
    int s0, p0, so0, eo0, ef0;
    do_reset();
    width = 4'd8;
    height = 4'd8;
    pix_ready = 1'b1;
    s0 = nscan;
    p0 = npop;
    so0 = nsof;
    eo0 = neol;
    ef0 = neof;
    run = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step();
      if (nscan - s0 >= 66) break;
    end
    drain("grid");
    nchk++;
    if (npop - p0 != 66) begin
      nfail++;
      $display("FAIL grid_count: %0d pixels, required 66", npop - p0);
    end
    nchk++;
    if (neol - eo0 != 8 || neof - ef0 != 1 || nsof - so0 != 2) begin
      nfail++;
      $display("FAIL grid_tags: eol=%0d eof=%0d sof=%0d, required 8 1 2",
               neol - eo0, neof - ef0, nsof - so0);
    end
  endtask

  task automatic test_reset_mid();
    int found = 0;
    width = 4'd3;
    height = 4'd2;
    pix_ready = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (sb.size() == 4 && !scan_en) begin
        found = 1;
        break;
      end
    end
    nchk++;
    if (found == 0 || !pix_valid) begin
      nfail++;
      $display("FAIL rmid_setup: outstanding=%0d pix_valid=%b, required 4 and 1", sb.size(), pix_valid);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    nchk++;
    if (pix_valid !== 1'b0) begin
      nfail++;
      $display("FAIL rmid_flush: pix_valid=%b after reset, required 0", pix_valid);
    end
    @(negedge clk);
    nchk++;
    if (pix_valid !== 1'b0) begin
      nfail++;
      $display("FAIL rmid_stale: pix_valid=%b one cycle later, required 0", pix_valid);
    end
    @(negedge clk);
    nchk++;
    if (pix_valid !== 1'b1) begin
      nfail++;
      $display("FAIL rmid_restart: pix_valid=%b, required 1", pix_valid);
    end
    step();
    pix_ready = 1'b1;
    repeat (10) step();
    drain("rmid");
  endtask

  task automatic test_alternating();
    int over = 0;
    int p0 = npop;
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pix_ready = ~pix_ready;
      @(negedge clk);
      if (sb.size() > FD) over++;
      step();
    end
    nchk++;
    if (over != 0) begin
      nfail++;
      $display("FAIL alt_bound: outstanding exceeded %0d in %0d cycles, required 0", FD, over);
    end
    nchk++;
    if (npop - p0 < 15) begin
      nfail++;
      $display("FAIL alt_progress: %0d pixels delivered, required at least 15", npop - p0);
    end
    drain("alt");
  endtask

  initial begin
    test_reset();
    test_raster();
    test_backpressure();
    test_pause();
    test_full_grid();
    test_reset_mid();
    test_alternating();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
